// File: rtl/cfa_pkg.sv
// Shared types and helpers for the bit-serial adder slice.
package cfa_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the bit counter
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester and the serial adder.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, op_a, op_b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, op_a, op_b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/FA.sv
// One-bit full-adder cell.
module FA (
  output logic sum,
  output logic carry,
  input  logic inp1,
  input  logic inp2,
  input  logic inp3
);

  assign sum   = inp1 ^ inp2 ^ inp3;
  assign carry = (inp1 & inp2) | (inp1 & inp3) | (inp2 & inp3);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder evaluation per clock, LSB first,
// carry held in a flop between bits.
module serial_adder
  import cfa_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);

  localparam int unsigned CNT_W = clog2(WIDTH);
  localparam int unsigned PART_W = WIDTH - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0]  sa;
  logic [WIDTH-1:0]  sb;
  // Upper result bits collected so far; the final bit comes straight from the FA
  logic [PART_W-1:0] partial;
  logic              carry;
  logic [CNT_W-1:0]  cnt;

  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              busy_q;
  logic              done_q;

  logic              fa_sum;
  logic              fa_carry;

  logic              accept_c;
  logic              step_c;
  logic              last_c;

  // The only arithmetic element: one full-adder cell on the operand LSBs
  FA u_fa (
    .sum   (fa_sum),
    .carry (fa_carry),
    .inp1  (sa[0]),
    .inp2  (sb[0]),
    .inp3  (carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (bus.start) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == CNT_LAST) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = bus.start ? ST_RUN : ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Control decode: operand capture, bit step, final bit
  always_comb begin
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        accept_c = bus.start;
      end
      ST_RUN: begin
        step_c = 1'b1;
        last_c = (cnt == CNT_LAST);
      end
      ST_DONE: begin
        accept_c = bus.start;
      end
      default: begin
        accept_c = 1'b0;
      end
    endcase
  end

  // Operand shifters, carry flop, partial result and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sa      <= '0;
      sb      <= '0;
      partial <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
    end else if (accept_c) begin
      sa      <= bus.op_a;
      sb      <= bus.op_b;
      partial <= '0;
      carry   <= bus.cin;
      cnt     <= '0;
    end else if (step_c) begin
      sa      <= sa >> 1;
      sb      <= sb >> 1;
      partial <= PART_W'({fa_sum, partial} >> 1);
      carry   <= fa_carry;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  // Registered status and result; sum/cout change only on the final bit
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      busy_q <= (next_state == ST_RUN);
      done_q <= last_c;
      if (last_c) begin
        sum_q  <= {fa_sum, partial};
        cout_q <= fa_carry;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
